sram_loader_port: RTL and testbench

- Responder (memory) end of the registered SRAM bus driven by the 6502 top level. That bus presents `addr`, the write strobe `sram_oe` and write data `sram_dout`; this block returns `sram_din`.
- Holds a block-RAM array that the CPU reads and writes.
- Also carries a host byte-stream loader that writes framed payloads into the same array while holding the CPU off.
- Sits beside the CPU top; its `cpu_hold` output is gated into the CPU reset by the integrating level.

---
 rtl/sram_loader_port.sv | 129 ++++++++++++
 tb/tb_sram_loader_port.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_loader_port.sv
// rtl/sram_loader_port.sv - CPU-side block RAM with framed host byte-stream loader
module sram_loader_port #(
    parameter int          AW        = 11,
    parameter logic [7:0]  SYNC      = 8'h55,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        sram_oe,
    input  logic [7:0]  sram_dout,
    output logic [7:0]  sram_din,
    input  logic [7:0]  ld_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    output logic        cpu_hold,
    output logic        ld_done,
    output logic        ld_err
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        IDLE,
        AHI,
        ALO,
        LEN,
        DATA,
        CSUM,
        DONE
    } state_t;

    logic [7:0]  mem [0:DEPTH-1];
    state_t      state;
    logic [15:0] ptr;
    logic [7:0]  sum;
    logic [8:0]  cnt;
    logic        ld_acc;
    logic        ld_we;
    logic        cpu_we;
    logic        unused_hi;

    assign unused_hi = &{1'b0, addr[15:AW], ptr[15:AW]};

    // A byte arriving on the same edge as reset is dropped with the frame.
    assign ld_acc = reset && ld_valid && ld_ready;
    assign ld_we  = ld_acc && (state == DATA);
    assign cpu_we = sram_oe && !cpu_hold;

    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ptr[AW-1:0]] <= ld_data;
        end else if (cpu_we) begin
            mem[addr[AW-1:0]] <= sram_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || cpu_hold) begin
            sram_din <= 8'h00;
        end else begin
            sram_din <= mem[addr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
            ld_done  <= 1'b0;
            ld_err   <= 1'b0;
            ld_ready <= 1'b0;
            ptr      <= 16'h0000;
            sum      <= 8'h00;
            cnt      <= 9'd0;
        end else begin
            ld_done  <= 1'b0;
            ld_ready <= 1'b1;
            if (state == DONE) begin
                state    <= IDLE;
                cpu_hold <= 1'b0;
            end else if (ld_acc) begin
                case (state)
                    IDLE: begin
                        if (ld_data == SYNC) begin
                            state    <= AHI;
                            ld_err   <= 1'b0;
                            cpu_hold <= 1'b1;
                            sum      <= 8'h00;
                        end
                    end
                    AHI: begin
                        ptr[15:8] <= ld_data;
                        sum       <= sum + ld_data;
                        state     <= ALO;
                    end
                    ALO: begin
                        ptr[7:0] <= ld_data;
                        sum      <= sum + ld_data;
                        state    <= LEN;
                    end
                    LEN: begin
                        cnt   <= (ld_data == 8'h00) ? 9'd256 : {1'b0, ld_data};
                        sum   <= sum + ld_data;
                        state <= DATA;
                    end
                    DATA: begin
                        ptr <= ptr + 16'd1;
                        sum <= sum + ld_data;
                        cnt <= cnt - 9'd1;
                        if (cnt == 9'd1) begin
                            state <= CSUM;
                        end
                    end
                    CSUM: begin
                        ld_err   <= (8'(sum + ld_data) != 8'h00);
                        ld_done  <= 1'b1;
                        ld_ready <= 1'b0;
                        state    <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_loader_port.sv
// tb/tb_sram_loader_port.sv - vector table and scoreboard bench for sram_loader_port
module tb_sram_loader_port;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic        sram_oe;
    logic [7:0]  sram_dout;
    logic [7:0]  sram_din;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        cpu_hold;
    logic        ld_done;
    logic        ld_err;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [7:0] sb[$];
    logic [7:0] txq[$];

    typedef struct {
        logic        oe;
        logic [15:0] a;
        logic [7:0]  d;
        logic        chk;
        logic [7:0]  exp;
    } cpu_vec_t;

    cpu_vec_t vecs[6];

    sram_loader_port #(.AW(11), .SYNC(8'h55), .INIT_FILE("")) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .sram_oe  (sram_oe),
        .sram_dout(sram_dout),
        .sram_din (sram_din),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .cpu_hold (cpu_hold),
        .ld_done  (ld_done),
        .ld_err   (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ld_done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle; a read expectation is queued now and compared when data returns.
    task automatic cpu_op(input logic oe, input logic [15:0] a, input logic [7:0] d,
                          input logic c, input logic [7:0] e);
        logic [7:0] want;
        addr      = a;
        sram_oe   = oe;
        sram_dout = d;
        if (c) sb.push_back(e);
        tick();
        sram_oe = 1'b0;
        if (c) begin
            want = sb.pop_front();
            chk($sformatf("cpu_rd_%h", a), {8'h00, sram_din}, {8'h00, want});
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        ld_data  = b;
        ld_valid = 1'b1;
        while (ld_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ld_ready_wait", {15'h0, ld_ready}, 16'h0001);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic send_all();
        while (txq.size() > 0) send_byte(txq.pop_front());
    endtask

    initial begin
        int d0;

        vecs[0] = '{oe: 1'b1, a: 16'h0123, d: 8'hA5, chk: 1'b0, exp: 8'h00};
        vecs[1] = '{oe: 1'b0, a: 16'h0123, d: 8'h00, chk: 1'b1, exp: 8'hA5};
        vecs[2] = '{oe: 1'b0, a: 16'h3123, d: 8'h00, chk: 1'b1, exp: 8'hA5};
        vecs[3] = '{oe: 1'b1, a: 16'h0200, d: 8'h3C, chk: 1'b0, exp: 8'h00};
        vecs[4] = '{oe: 1'b1, a: 16'h0200, d: 8'h77, chk: 1'b1, exp: 8'h3C};
        vecs[5] = '{oe: 1'b0, a: 16'h4200, d: 8'h00, chk: 1'b1, exp: 8'h77};

        reset     = 1'b0;
        addr      = 16'h0000;
        sram_oe   = 1'b0;
        sram_dout = 8'h00;
        ld_data   = 8'h00;
        ld_valid  = 1'b0;
        tick();
        tick();
        chk("rst_cpu_hold", {15'h0, cpu_hold}, 16'h0000);
        chk("rst_ld_done", {15'h0, ld_done}, 16'h0000);
        chk("rst_ld_err", {15'h0, ld_err}, 16'h0000);
        chk("rst_ld_ready", {15'h0, ld_ready}, 16'h0000);
        chk("rst_sram_din", {8'h00, sram_din}, 16'h0000);
        reset = 1'b1;
        tick();
        chk("post_rst_ready", {15'h0, ld_ready}, 16'h0001);

        for (int i = 0; i < 6; i++) begin
            cpu_op(vecs[i].oe, vecs[i].a, vecs[i].d, vecs[i].chk, vecs[i].exp);
        end

        // Good frame, with leading garbage and a blocked CPU write mid-frame.
        d0  = done_cnt;
        txq = '{8'h00, 8'hFF};
        send_all();
        chk("garbage_no_hold", {15'h0, cpu_hold}, 16'h0000);
        send_byte(8'h55);
        chk("sync_hold", {15'h0, cpu_hold}, 16'h0001);
        txq = '{8'h00, 8'h10, 8'h03, 8'h11};
        send_all();
        cpu_op(1'b1, 16'h0010, 8'h5A, 1'b1, 8'h00);
        txq = '{8'h22, 8'h33, 8'h87};
        send_all();
        chk("done_pulse", {15'h0, ld_done}, 16'h0001);
        chk("done_hold", {15'h0, cpu_hold}, 16'h0001);
        chk("done_not_ready", {15'h0, ld_ready}, 16'h0000);
        chk("good_err", {15'h0, ld_err}, 16'h0000);
        tick();
        chk("after_done_pulse", {15'h0, ld_done}, 16'h0000);
        chk("after_done_hold", {15'h0, cpu_hold}, 16'h0000);
        chk("done_count", 16'(done_cnt - d0), 16'h0001);
        cpu_op(1'b0, 16'h0010, 8'h00, 1'b1, 8'h11);
        cpu_op(1'b0, 16'h0011, 8'h00, 1'b1, 8'h22);
        cpu_op(1'b0, 16'h0012, 8'h00, 1'b1, 8'h33);

        // Bad checksum, sticky error, cleared by the next SYNC; that frame wraps.
        txq = '{8'h55, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88};
        send_all();
        tick();
        chk("bad_err", {15'h0, ld_err}, 16'h0001);
        send_byte(8'h12);
        chk("err_sticky", {15'h0, ld_err}, 16'h0001);
        send_byte(8'h55);
        chk("err_clr_sync", {15'h0, ld_err}, 16'h0000);
        txq = '{8'h07, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h93};
        send_all();
        tick();
        chk("wrap_err", {15'h0, ld_err}, 16'h0000);
        cpu_op(1'b0, 16'h07FF, 8'h00, 1'b1, 8'hAA);
        cpu_op(1'b0, 16'h0000, 8'h00, 1'b1, 8'hBB);

        // Length 0 means 256 data bytes, with occasional valid gaps.
        txq = '{8'h55, 8'h01, 8'h00, 8'h00};
        send_all();
        for (int i = 0; i < 256; i++) begin
            if (i % 64 == 63) tick();
            send_byte(8'(i));
        end
        chk("len0_no_early_done", {15'h0, ld_done}, 16'h0000);
        send_byte(8'h7F);
        chk("len0_done", {15'h0, ld_done}, 16'h0001);
        chk("len0_err", {15'h0, ld_err}, 16'h0000);
        tick();
        cpu_op(1'b0, 16'h0100, 8'h00, 1'b1, 8'h00);
        cpu_op(1'b0, 16'h017F, 8'h00, 1'b1, 8'h7F);
        cpu_op(1'b0, 16'h01FF, 8'h00, 1'b1, 8'hFF);
        cpu_op(1'b0, 16'h0200, 8'h00, 1'b1, 8'h77);

        // Reset in the middle of DATA keeps the bytes already written.
        txq = '{8'h55, 8'h03, 8'h00, 8'h04, 8'hC1, 8'hC2};
        send_all();
        reset = 1'b0;
        tick();
        chk("midrst_hold", {15'h0, cpu_hold}, 16'h0000);
        chk("midrst_ready", {15'h0, ld_ready}, 16'h0000);
        chk("midrst_err", {15'h0, ld_err}, 16'h0000);
        chk("midrst_din", {8'h00, sram_din}, 16'h0000);
        reset = 1'b1;
        tick();
        send_byte(8'h04);
        chk("midrst_idle", {15'h0, cpu_hold}, 16'h0000);
        cpu_op(1'b0, 16'h0300, 8'h00, 1'b1, 8'hC1);
        cpu_op(1'b0, 16'h0301, 8'h00, 1'b1, 8'hC2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
